bsearch_finder: RTL and testbench



---
 rtl/bsearch_finder_if.sv | 28 ++
 rtl/bsearch_finder.sv | 128 ++++++++++++
 tb/tb_bsearch_finder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bsearch_finder_if.sv
// Comparator-side bundle for bsearch_finder: start request, GT/EQ/LT verdict,
// candidate guess and search results.
interface bsearch_finder_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPW = $clog2(WIDTH + 2)
);
  logic             inStart;
  logic             inGT;
  logic             inEQ;
  logic             inLT;
  logic [WIDTH-1:0] outGuess;
  logic             outBusy;
  logic             outDone;
  logic             outFound;
  logic             outError;
  logic [WIDTH-1:0] outValue;
  logic [STEPW-1:0] outSteps;

  modport master (
    input  inStart, inGT, inEQ, inLT,
    output outGuess, outBusy, outDone, outFound, outError, outValue, outSteps
  );

  modport slave (
    output inStart, inGT, inEQ, inLT,
    input  outGuess, outBusy, outDone, outFound, outError, outValue, outSteps
  );
endinterface

// File: rtl/bsearch_finder.sv
// Binary-search initiator: drives a candidate into a magnitude comparator and
// narrows [lo, hi] from the GT/EQ/LT verdict until the target is located.
module bsearch_finder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPW = $clog2(WIDTH + 2)
) (
  input logic            clk,
  input logic            reset,
  bsearch_finder_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUESS = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH:0]   ONE_W = (WIDTH + 1)'(1);
  localparam logic [STEPW-1:0] ONE_S = STEPW'(1);

  state_t           state_q, state_d;
  logic [WIDTH:0]   lo_q, lo_d;
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic             found_q, found_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [STEPW-1:0] steps_q, steps_d;
  logic [WIDTH:0]   guess_ext;
  logic [2:0]       verdict;

  assign guess_ext = {1'b0, guess_q};
  assign verdict   = {bus.inGT, bus.inEQ, bus.inLT};

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    guess_d = guess_q;
    found_d = found_q;
    error_d = error_q;
    value_d = value_q;
    steps_d = steps_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.inStart) begin
          lo_d    = '0;
          hi_d    = {1'b0, {WIDTH{1'b1}}};
          found_d = 1'b0;
          error_d = 1'b0;
          value_d = '0;
          steps_d = '0;
          state_d = S_GUESS;
        end
      end

      S_GUESS: begin
        // lo <= hi <= 2^WIDTH-1 here, so the sum cannot overflow WIDTH+1 bits
        guess_d = WIDTH'((lo_q + hi_q) >> 1);
        state_d = S_CHECK;
      end

      S_CHECK: begin
        steps_d = steps_q + ONE_S;
        unique case (verdict)
          3'b010: begin
            found_d = 1'b1;
            value_d = guess_q;
            state_d = S_DONE;
          end
          3'b100: begin
            // a GT verdict at guess 0 leaves nothing below; hi would wrap
            if (guess_q == '0) begin
              state_d = S_DONE;
            end else begin
              hi_d    = guess_ext - ONE_W;
              state_d = (lo_q > hi_d) ? S_DONE : S_GUESS;
            end
          end
          3'b001: begin
            lo_d    = guess_ext + ONE_W;
            state_d = (lo_d > hi_q) ? S_DONE : S_GUESS;
          end
          default: begin
            error_d = 1'b1;
            found_d = 1'b0;
            state_d = S_DONE;
          end
        endcase
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      guess_q <= '0;
      found_q <= 1'b0;
      error_q <= 1'b0;
      value_q <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      guess_q <= guess_d;
      found_q <= found_d;
      error_q <= error_d;
      value_q <= value_d;
      steps_q <= steps_d;
    end
  end

  assign bus.outGuess = guess_q;
  assign bus.outBusy  = (state_q == S_GUESS) || (state_q == S_CHECK);
  assign bus.outDone  = (state_q == S_DONE);
  assign bus.outFound = found_q;
  assign bus.outError = error_q;
  assign bus.outValue = value_q;
  assign bus.outSteps = steps_q;

endmodule

// File: tb/tb_bsearch_finder.sv
// Bench for bsearch_finder: a comparator model answers the DUT's guesses, and
// results are checked against table entries and a plain-arithmetic search model.
module tb_bsearch_finder;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned STEPW = $clog2(WIDTH + 2);
  localparam int          MAXV  = (1 << WIDTH) - 1;

  logic clk;
  logic reset;

  bsearch_finder_if #(.WIDTH(WIDTH), .STEPW(STEPW)) bus ();

  bsearch_finder #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // comparator model: 0 = honest vs target, 1 = always LT, 2 = no flag, 3 = GT+EQ
  int target;
  int mode;
  assign bus.inGT = (mode == 0) ? (int'(bus.outGuess) >  target) : (mode == 3);
  assign bus.inEQ = (mode == 0) ? (int'(bus.outGuess) == target) : (mode == 3);
  assign bus.inLT = (mode == 0) ? (int'(bus.outGuess) <  target) : (mode == 1);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference search computed directly from the range-halving rules
  int m_guesses[$];
  int m_found, m_error, m_value, m_steps;

  function automatic void model(input int t, input int m);
    int lo, hi, g;
    bit gt, eq, lt;
    m_guesses.delete();
    m_found = 0; m_error = 0; m_value = 0; m_steps = 0;
    lo = 0;
    hi = MAXV;
    while (1) begin
      g = (lo + hi) / 2;
      m_guesses.push_back(g);
      m_steps++;
      gt = (m == 0) ? (g > t) : (m == 3);
      eq = (m == 0) ? (g == t) : (m == 3);
      lt = (m == 0) ? (g < t) : (m == 1);
      if (int'(gt) + int'(eq) + int'(lt) != 1) begin
        m_error = 1;
        break;
      end
      if (eq) begin
        m_found = 1;
        m_value = g;
        break;
      end
      if (gt) begin
        if (g == 0) break;
        hi = g - 1;
      end else begin
        lo = g + 1;
      end
      if (lo > hi) break;
    end
  endfunction

  // runs one search; inStart is sampled at the first edge (E) of this task
  task automatic run_search(input string tag, input int t, input int m, input bit poke,
                            input int e_found, input int e_error, input int e_value,
                            input int e_steps);
    int got[$];
    bit done_seen;
    target = t;
    mode   = m;
    model(t, m);
    bus.inStart = 1'b1;
    @(posedge clk); #1;
    bus.inStart = 1'b0;
    chk({tag, ".start_done"}, int'(bus.outDone), 0);
    chk({tag, ".start_busy"}, int'(bus.outBusy), 1);
    chk({tag, ".start_steps"}, int'(bus.outSteps), 0);
    done_seen = 1'b0;
    for (int i = 0; i < int'(WIDTH) + 3; i++) begin
      @(posedge clk); #1;
      got.push_back(int'(bus.outGuess));
      if (poke) bus.inStart = 1'b1;
      @(posedge clk); #1;
      bus.inStart = 1'b0;
      if (bus.outDone) begin
        done_seen = 1'b1;
        break;
      end
    end
    chk({tag, ".done_in_bound"}, int'(done_seen), 1);
    chk({tag, ".n_cmp"}, got.size(), m_guesses.size());
    for (int i = 0; i < got.size() && i < m_guesses.size(); i++)
      chk($sformatf("%s.guess%0d", tag, i), got[i], m_guesses[i]);
    chk({tag, ".busy_at_done"}, int'(bus.outBusy), 0);
    chk({tag, ".found"}, int'(bus.outFound), e_found);
    chk({tag, ".error"}, int'(bus.outError), e_error);
    chk({tag, ".value"}, int'(bus.outValue), e_value);
    chk({tag, ".steps"}, int'(bus.outSteps), e_steps);
    // results must hold in DONE with no new start
    @(posedge clk); #1;
    chk({tag, ".hold_done"}, int'(bus.outDone), 1);
    chk({tag, ".hold_steps"}, int'(bus.outSteps), e_steps);
  endtask

  typedef struct {
    int target;
    int mode;
    int found;
    int error;
    int value;
    int steps;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{target: 7,  mode: 0, found: 1, error: 0, value: 7,  steps: 1};
    vecs[1] = '{target: 15, mode: 0, found: 1, error: 0, value: 15, steps: 5};
    vecs[2] = '{target: 0,  mode: 0, found: 1, error: 0, value: 0,  steps: 4};
    vecs[3] = '{target: 0,  mode: 1, found: 0, error: 0, value: 0,  steps: 5};
    vecs[4] = '{target: 0,  mode: 2, found: 0, error: 1, value: 0,  steps: 1};
    vecs[5] = '{target: 0,  mode: 3, found: 0, error: 1, value: 0,  steps: 1};
    vecs[6] = '{target: 8,  mode: 0, found: 1, error: 0, value: 8,  steps: 4};
    vecs[7] = '{target: 13, mode: 0, found: 1, error: 0, value: 13, steps: 3};

    target = 0;
    mode   = 0;
    bus.inStart = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.guess", int'(bus.outGuess), 0);
    chk("rst.busy",  int'(bus.outBusy),  0);
    chk("rst.done",  int'(bus.outDone),  0);
    chk("rst.found", int'(bus.outFound), 0);
    chk("rst.error", int'(bus.outError), 0);
    chk("rst.value", int'(bus.outValue), 0);
    chk("rst.steps", int'(bus.outSteps), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // table vectors, back to back: each restart comes from DONE
    for (int v = 0; v < 8; v++)
      run_search($sformatf("vec%0d", v), vecs[v].target, vecs[v].mode, 1'b0,
                 vecs[v].found, vecs[v].error, vecs[v].value, vecs[v].steps);

    // inStart held high through every CHECK must not disturb the search
    run_search("poke13", 13, 0, 1'b1, 1, 0, 13, 3);

    // asynchronous reset in the middle of a search
    target = 13;
    mode   = 0;
    bus.inStart = 1'b1;
    @(posedge clk); #1;
    bus.inStart = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("mid.busy_before", int'(bus.outBusy), 1);
    reset = 1'b1;
    #1;
    chk("mid.guess", int'(bus.outGuess), 0);
    chk("mid.busy",  int'(bus.outBusy),  0);
    chk("mid.done",  int'(bus.outDone),  0);
    chk("mid.found", int'(bus.outFound), 0);
    chk("mid.error", int'(bus.outError), 0);
    chk("mid.value", int'(bus.outValue), 0);
    chk("mid.steps", int'(bus.outSteps), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid.idle_busy", int'(bus.outBusy), 0);
    run_search("after_rst", 13, 0, 1'b0, 1, 0, 13, 3);

    // randomized targets and occasional malformed comparators vs. the model
    for (int r = 0; r < 40; r++) begin
      int t, m;
      t = int'($urandom_range(0, MAXV));
      m = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 3));
      model(t, m);
      run_search($sformatf("rnd%0d", r), t, m, 1'($urandom_range(0, 1)),
                 m_found, m_error, m_value, m_steps);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
